// File: rtl/icache_line_fetcher.sv
// Instruction fetch stage with a direct-mapped I-cache of multi-word lines.
// Hits issue combinationally; misses fill a whole line one word request at a time.
module icache_line_fetcher #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int INDEX_BITS = 6,
  parameter int OFFS_BITS  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ena,
  input  logic              in_rollback,
  input  logic              in_flush,
  input  logic [ADDR_W-1:0] in_pc,
  input  logic              in_pred_taken,
  input  logic              in_rs_ok,
  input  logic              in_rob_ok,
  input  logic              in_lsq_ok,
  output logic              out_fetch_valid,
  output logic [DATA_W-1:0] out_inst,
  output logic [ADDR_W-1:0] out_pc,
  output logic              out_pred_taken,
  output logic              out_mem_req,
  output logic [ADDR_W-1:0] out_mem_addr,
  input  logic              in_mem_ready,
  input  logic [DATA_W-1:0] in_mem_data
);

  localparam int LINES = 1 << INDEX_BITS;
  localparam int WORDS = 1 << OFFS_BITS;
  localparam int TAG_W = ADDR_W - INDEX_BITS - OFFS_BITS - 2;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_DRAIN
  } state_t;

  state_t                  state_q, state_d;
  logic [LINES-1:0]        valid_q, valid_d;
  logic [INDEX_BITS-1:0]   fill_index_q, fill_index_d;
  logic [TAG_W-1:0]        fill_tag_q, fill_tag_d;
  logic [OFFS_BITS-1:0]    cnt_q, cnt_d;

  logic [TAG_W-1:0]        tag_mem  [LINES];
  logic [DATA_W-1:0]       data_mem [LINES*WORDS];

  logic [OFFS_BITS-1:0]    pc_offs;
  logic [INDEX_BITS-1:0]   pc_index;
  logic [TAG_W-1:0]        pc_tag;
  logic                    hit;
  logic                    abort;
  logic                    data_we;
  logic                    line_done;
  logic                    unused_pc_lsb;

  assign pc_offs       = in_pc[OFFS_BITS+1:2];
  assign pc_index      = in_pc[INDEX_BITS+OFFS_BITS+1:OFFS_BITS+2];
  assign pc_tag        = in_pc[ADDR_W-1:INDEX_BITS+OFFS_BITS+2];
  assign unused_pc_lsb = ^in_pc[1:0];

  assign hit   = valid_q[pc_index] && (tag_mem[pc_index] == pc_tag);
  assign abort = in_rollback || in_flush;

  // Issue path: purely combinational, zero-cycle latency on a hit
  assign out_fetch_valid = hit && !abort && in_rs_ok && in_rob_ok && in_lsq_ok;
  assign out_inst        = data_mem[{pc_index, pc_offs}];
  assign out_pc          = in_pc;
  assign out_pred_taken  = in_pred_taken;

  // Request address always follows the latched fill target, never the live PC
  assign out_mem_addr = {fill_tag_q, fill_index_q, cnt_q, 2'b00};

  always_comb begin
    state_d      = state_q;
    valid_d      = valid_q;
    fill_index_d = fill_index_q;
    fill_tag_d   = fill_tag_q;
    cnt_d        = cnt_q;
    data_we      = 1'b0;
    line_done    = 1'b0;
    out_mem_req  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (ena && !hit && !abort) begin
          fill_index_d      = pc_index;
          fill_tag_d        = pc_tag;
          valid_d[pc_index] = 1'b0;
          cnt_d             = '0;
          state_d           = S_REQ;
        end
      end
      S_REQ: begin
        out_mem_req = 1'b1;
        state_d     = abort ? S_DRAIN : S_WAIT;
      end
      S_WAIT: begin
        if (abort) begin
          // A word arriving with the abort is simply dropped
          state_d = in_mem_ready ? S_IDLE : S_DRAIN;
        end else if (in_mem_ready) begin
          data_we = 1'b1;
          if (cnt_q == '1) begin
            valid_d[fill_index_q] = 1'b1;
            line_done             = 1'b1;
            state_d               = S_IDLE;
          end else begin
            cnt_d   = cnt_q + OFFS_BITS'(1);
            state_d = S_REQ;
          end
        end
      end
      S_DRAIN: begin
        if (in_mem_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Flush wins over a line completing in the same cycle
    if (in_flush) valid_d = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      valid_q      <= '0;
      fill_index_q <= '0;
      fill_tag_q   <= '0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      valid_q      <= valid_d;
      fill_index_q <= fill_index_d;
      fill_tag_q   <= fill_tag_d;
      cnt_q        <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (data_we) data_mem[{fill_index_q, cnt_q}] <= in_mem_data;
    if (line_done) tag_mem[fill_index_q] <= fill_tag_q;
  end

endmodule

// File: tb/tb_icache_line_fetcher.sv
// Scoreboard bench for icache_line_fetcher with a fixed-latency word memory model.
module tb_icache_line_fetcher;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int LAT    = 2;

  logic              clk;
  logic              rst;
  logic              ena;
  logic              in_rollback;
  logic              rb_main;
  logic              rb_mem = 1'b0;
  logic              in_flush;
  logic [ADDR_W-1:0] in_pc;
  logic              in_pred_taken;
  logic              in_rs_ok;
  logic              in_rob_ok;
  logic              in_lsq_ok;
  logic              out_fetch_valid;
  logic [DATA_W-1:0] out_inst;
  logic [ADDR_W-1:0] out_pc;
  logic              out_pred_taken;
  logic              out_mem_req;
  logic [ADDR_W-1:0] out_mem_addr;
  logic              in_mem_ready = 1'b0;
  logic [DATA_W-1:0] in_mem_data  = '0;

  int n_checks = 0;
  int n_errors = 0;

  logic [ADDR_W-1:0] exp_req_q[$];
  int                pend = 0;
  logic [ADDR_W-1:0] pend_addr = '0;
  bit                rb_arm = 1'b0;
  bit                rb_fired = 1'b0;

  assign in_rollback = rb_main | rb_mem;

  icache_line_fetcher #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .INDEX_BITS(6), .OFFS_BITS(2)
  ) dut (
    .clk(clk), .rst(rst), .ena(ena), .in_rollback(in_rollback), .in_flush(in_flush),
    .in_pc(in_pc), .in_pred_taken(in_pred_taken), .in_rs_ok(in_rs_ok),
    .in_rob_ok(in_rob_ok), .in_lsq_ok(in_lsq_ok), .out_fetch_valid(out_fetch_valid),
    .out_inst(out_inst), .out_pc(out_pc), .out_pred_taken(out_pred_taken),
    .out_mem_req(out_mem_req), .out_mem_addr(out_mem_addr),
    .in_mem_ready(in_mem_ready), .in_mem_data(in_mem_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [DATA_W-1:0] mem_word(input logic [ADDR_W-1:0] a);
    return {a[15:0] ^ 16'hC0DE, ~a[15:0]};
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Memory: answers each request LAT cycles later; checks requests against the scoreboard
  always @(negedge clk) begin
    in_mem_ready = 1'b0;
    rb_mem       = 1'b0;
    if (pend != 0) begin
      pend = pend - 1;
      if (pend == 0) begin
        in_mem_ready = 1'b1;
        in_mem_data  = mem_word(pend_addr);
        if (rb_arm && !rb_fired) begin
          rb_mem   = 1'b1;
          rb_fired = 1'b1;
        end
      end
    end
    if (out_mem_req) begin
      check("one_outstanding", pend, 0);
      if (exp_req_q.size() == 0) check("req_unexpected", out_mem_req, 0);
      else check("req_addr", out_mem_addr, exp_req_q.pop_front());
      pend_addr = out_mem_addr;
      pend      = LAT;
    end
  end

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic push_line(input logic [ADDR_W-1:0] a);
    for (int i = 0; i < 4; i++) exp_req_q.push_back({a[ADDR_W-1:4], 4'b0} + ADDR_W'(4 * i));
  endtask

  task automatic wait_hit(input string tag, input int budget, output int n);
    n = 0;
    while (!out_fetch_valid && n < budget) begin
      next();
      #2;
      n++;
    end
    check(tag, out_fetch_valid, 1);
  endtask

  task automatic wait_req(input int budget);
    int n;
    n = 0;
    while (!out_mem_req && n < budget) begin
      next();
      #2;
      n++;
    end
    check("req_seen", out_mem_req, 1);
  endtask

  initial begin
    int n;
    rst = 1'b1; ena = 1'b0; rb_main = 1'b0; in_flush = 1'b0; in_pc = '0;
    in_pred_taken = 1'b0; in_rs_ok = 1'b1; in_rob_ok = 1'b1; in_lsq_ok = 1'b1;
    repeat (3) next();
    #2;
    check("rst_req", out_mem_req, 0);
    check("rst_addr", out_mem_addr, 0);
    check("rst_valid", out_fetch_valid, 0);
    next();
    rst = 1'b0;

    // Cold miss at 0x100
    next();
    in_pc = 32'h100; ena = 1'b1; in_pred_taken = 1'b1;
    push_line(32'h100);
    #2;
    check("cold_miss", out_fetch_valid, 0);
    wait_hit("cold_hit", 60, n);
    check("cold_latency", n, 13);
    check("cold_inst", out_inst, mem_word(32'h100));
    check("cold_pc", out_pc, 32'h100);
    check("cold_pred", out_pred_taken, 1);
    in_pred_taken = 1'b0;

    for (int i = 1; i < 4; i++) begin
      next();
      in_pc = 32'h100 + 32'(4 * i);
      #2;
      check("seq_valid", out_fetch_valid, 1);
      check("seq_inst", out_inst, mem_word(in_pc));
      check("seq_noreq", out_mem_req, 0);
    end

    // Hit-under-fill, then rollback in WAIT of word 1
    next();
    in_pc = 32'h200;
    exp_req_q.push_back(32'h200);
    exp_req_q.push_back(32'h204);
    #2;
    next();
    in_pc = 32'h104;
    #2;
    check("huf_valid", out_fetch_valid, 1);
    check("huf_inst", out_inst, mem_word(32'h104));
    n = 0;
    while (exp_req_q.size() != 0 && n < 40) begin
      next();
      #2;
      check("huf_valid", out_fetch_valid, 1);
      n++;
    end
    check("huf_reqs_done", exp_req_q.size(), 0);
    rb_main = 1'b1;
    #1;
    check("rb_suppress", out_fetch_valid, 0);
    next();
    rb_main = 1'b0; in_pc = 32'h200; ena = 1'b0;
    #2;
    check("drain_noreq", out_mem_req, 0);
    next();
    #2;
    check("drain_discard", out_fetch_valid, 0);
    ena = 1'b1;
    push_line(32'h200);
    wait_hit("refill_200", 60, n);
    check("refill_200_inst", out_inst, mem_word(32'h200));

    // Rollback coincident with ready
    next();
    in_pc = 32'h300;
    exp_req_q.push_back(32'h300);
    rb_arm = 1'b1;
    n = 0;
    while (exp_req_q.size() != 0 && n < 40) begin
      next();
      #2;
      n++;
    end
    ena = 1'b0;
    repeat (6) next();
    #2;
    check("rb_coinc_fired", rb_fired, 1);
    check("rb_coinc_invalid", out_fetch_valid, 0);
    ena = 1'b1;
    push_line(32'h300);
    wait_hit("refill_300", 60, n);
    check("refill_300_inst", out_inst, mem_word(32'h300));

    // Conflict on index 0
    next();
    in_pc = 32'h000;
    push_line(32'h000);
    #2;
    wait_hit("fill_000", 60, n);
    next();
    in_pc = 32'h408;
    push_line(32'h400);
    #2;
    wait_hit("fill_400", 60, n);
    check("fill_400_inst", out_inst, mem_word(32'h408));
    next();
    in_pc = 32'h000; ena = 1'b0;
    #2;
    check("conflict_miss", out_fetch_valid, 0);
    ena = 1'b1;
    push_line(32'h000);
    wait_hit("refill_000", 60, n);
    next();
    in_pc = 32'h00C; in_rob_ok = 1'b0;
    #2;
    check("rob_block", out_fetch_valid, 0);
    repeat (3) begin
      next();
      #2;
      check("rob_noreq", out_mem_req, 0);
    end
    in_rob_ok = 1'b1;

    // Flush invalidates every line
    next();
    in_pc = 32'h010;
    push_line(32'h010);
    #2;
    wait_hit("fill_010", 60, n);
    next();
    in_pc = 32'h004;
    #2;
    check("pre_flush_000", out_fetch_valid, 1);
    in_flush = 1'b1;
    #1;
    check("flush_suppress", out_fetch_valid, 0);
    next();
    in_flush = 1'b0; ena = 1'b0;
    #2;
    check("flush_miss_000", out_fetch_valid, 0);
    next();
    in_pc = 32'h014;
    #2;
    check("flush_miss_010", out_fetch_valid, 0);

    // Flush during REQ
    next();
    ena = 1'b1; in_pc = 32'h500;
    exp_req_q.push_back(32'h500);
    #2;
    wait_req(10);
    in_flush = 1'b1;
    next();
    in_flush = 1'b0; ena = 1'b0;
    #2;
    check("flushreq_noreq", out_mem_req, 0);
    repeat (6) next();
    #2;
    check("flushreq_invalid", out_fetch_valid, 0);
    ena = 1'b1;
    push_line(32'h500);
    wait_hit("refill_500", 60, n);
    check("refill_500_inst", out_inst, mem_word(32'h500));

    // Reset mid-fill, late ready ignored
    next();
    in_pc = 32'h700;
    exp_req_q.push_back(32'h700);
    #2;
    wait_req(10);
    next();
    rst = 1'b1;
    next();
    rst = 1'b0; ena = 1'b0;
    #2;
    check("rst_mid_req", out_mem_req, 0);
    check("rst_mid_addr", out_mem_addr, 0);
    repeat (4) next();
    in_pc = 32'h500;
    #2;
    check("rst_mid_clear", out_fetch_valid, 0);
    check("rst_mid_noreq", out_mem_req, 0);

    check("req_queue_empty", exp_req_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
